// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    // Operand width used when the instantiating code does not override N.
    localparam int DEFAULT_N = 8;

    // Controller states; the encodings are fixed so other lab blocks can decode them.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must be able to hold the value n without wrapping.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_mult_bit_counter.sv
// Small up-counter that tracks how many multiplier bits have been consumed.
module bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Clear has priority so a new operation always starts counting from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_mult.sv
// Unsigned N x N sequential multiplier: one multiplier bit per RUN cycle.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = cnt_width(N);

    state_t         state_q, state_d;
    logic [2*N-1:0] multiplicand_q, multiplicand_d;
    logic [N-1:0]   multiplier_q, multiplier_d;
    logic [2*N-1:0] accum_q, accum_d;
    logic [2*N-1:0] product_q, product_d;
    logic [2*N-1:0] accumNext;
    logic [CW-1:0]  bitCnt;
    logic           acceptStart;
    logic           lastRun;

    // A new request is only taken when no multiplication is in flight.
    assign acceptStart = start && ((state_q == IDLE) || (state_q == DONE));
    assign lastRun     = (state_q == RUN) && (bitCnt == CW'(N - 1));

    bit_counter #(
        .W   (CW)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (acceptStart),
        .en  (state_q == RUN),
        .cnt (bitCnt)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN lasts exactly N cycles, DONE can chain straight into RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (lastRun) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs are pure decodes of the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Shift-and-add datapath; the product register only moves on the edge into DONE.
    always_comb begin
        accumNext      = multiplier_q[0] ? (accum_q + multiplicand_q) : accum_q;
        multiplicand_d = multiplicand_q;
        multiplier_d   = multiplier_q;
        accum_d        = accum_q;
        product_d      = product_q;
        if (acceptStart) begin
            multiplicand_d = {{N{1'b0}}, a};
            multiplier_d   = b;
            accum_d        = '0;
        end else if (state_q == RUN) begin
            accum_d        = accumNext;
            multiplicand_d = multiplicand_q << 1;
            multiplier_d   = multiplier_q >> 1;
            if (lastRun) begin
                product_d = accumNext;
            end
        end
    end

    // Datapath registers, all cleared by reset so an abandoned operation leaves p at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multiplicand_q <= '0;
            multiplier_q   <= '0;
            accum_q        <= '0;
            product_q      <= '0;
        end else begin
            multiplicand_q <= multiplicand_d;
            multiplier_q   <= multiplier_d;
            accum_q        <= accum_d;
            product_q      <= product_d;
        end
    end

    assign p = product_q;

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter N, default 8, meaning the operand width in bits; legal values are 2 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to multiply a by b.
REQ-005 SHALL have port a, input, N bits: unsigned multiplicand.
REQ-006 SHALL have port b, input, N bits: unsigned multiplier.
REQ-007 SHALL have port busy, output, 1 bit: high while a multiplication is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse; drives the ce input of the downstream result register.
REQ-009 SHALL have port p, output, 2N bits: unsigned product, held stable between done pulses.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-011 SHALL accept start only in IDLE or DONE; start sampled at edge t0 SHALL load the operand registers:
- multiplicand register (2N bits) <= a, zero-extended;
- multiplier shift register (N bits) <= b;
- accumulator (2N bits) <= 0;
- bit counter <= 0;
- state <= RUN.
REQ-012 In each RUN cycle the block SHALL do the following:
- if multiplier[0] is 1, accumulator <= accumulator + multiplicand, modulo 2^(2N) (no overflow is possible);
- multiplicand <= multiplicand shifted left by 1;
- multiplier <= multiplier shifted right by 1;
- counter <= counter + 1.
REQ-013 After exactly N RUN cycles, at edge t0+N, the block SHALL:
- enter DONE;
- load p with the final accumulator value;
- assert done for exactly one cycle.
REQ-014 p SHALL change only on the edge that enters DONE; it SHALL keep its old value during RUN.
REQ-015 busy SHALL be 1 exactly when the state is RUN; done SHALL be 1 exactly when the state is DONE.
REQ-016 start asserted during RUN SHALL be ignored: no restart and no queuing.
REQ-017 From DONE, start=1 SHALL go to RUN with new operands; start=0 SHALL go to IDLE. Back-to-back operations therefore have N+1 cycles per result.
REQ-018 a and b SHALL be sampled only on the start-accept edge; changes on a or b during RUN SHALL NOT affect the result.
REQ-019 Operand value 0 on either input SHALL still take the full N cycles and yield p=0; no early termination.
REQ-020 The counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-021 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state to IDLE;
- busy=0, done=0, p=0;
- accumulator, operand registers and counter to 0.
REQ-022 rst asserted mid-RUN SHALL abandon the operation: no done pulse and p=0.
REQ-023 After rst deasserts, the first accepted start SHALL behave exactly as in REQ-011.

Structure
REQ-024 The state encodings IDLE=2'd0, RUN=2'd1 and DONE=2'd2 SHALL be defined in the shared lab package/header, together with the default operand width constant.
REQ-025 The bit counter SHALL be a separate sub-module, bit_counter, with parameter W and ports clk, rst, clr, en, cnt.
REQ-026 The FSM, shift registers and adder SHALL stay in seq_mult; no other sub-modules.

Verification
REQ-027 N=8: rst pulse, then a=3, b=5, start for 1 cycle -> busy high for 8 cycles, then done pulse, p=15.
REQ-028 N=8: a=255, b=255 -> p=65025 (16'hFE01) on done.
REQ-029 N=8: a=0, b=200 -> done after 8 RUN cycles, p=0; then a=200, b=0 -> p=0.
REQ-030 N=8, start held high through a whole operation:
- start pulse during RUN is ignored, p unchanged until done;
- start high on the done cycle with a=7, b=6 -> RUN restarts with no IDLE cycle, next p=42.
REQ-031 Reset mid-RUN at cycle 4 of a=9, b=9:
- rst asserted -> p=0, busy=0 with no done pulse;
- a later start with a=9, b=9 -> p=81.
REQ-032 Randomised check, N=4 and N=16: 200 random pairs, with a and b toggled during RUN -> p equals a*b as sampled at start, every time.
